memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/memory_arbiter_if.sv | 31 +++
 rtl/wait_timer.sv | 30 +++
 rtl/memory_arbiter.sv | 141 ++++++++++++++
 tb/tb_memory_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM status encoding, arbiter FSM states and a small helper
// for recognising a pending data-side request.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IACC  = 3'd1,
    DACC  = 3'd2,
    IRESP = 3'd3,
    DRESP = 3'd4
  } arb_state_t;

  function automatic logic data_req(input logic ren, input logic wen);
    return ren | wen;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch, data and RAM signals around the memory arbiter.
// master = the arbiter itself, slave = the requesters plus the RAM.
interface memory_arbiter_if;
  logic        iRen;
  logic [31:0] iaddr;
  logic        dRen;
  logic        dWen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iHit;
  logic [31:0] iload;
  logic        dHit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  modport master (
    input  iRen, iaddr, dRen, dWen, daddr, dstore, ramload, ramstate,
    output iHit, iload, dHit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport slave (
    output iRen, iaddr, dRen, dWen, daddr, dstore, ramload, ramstate,
    input  iHit, iload, dHit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/wait_timer.sv
// Counts RAM wait cycles of the current access and flags when the TIMEOUT-th
// wait cycle is in progress.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_r;

  assign expired = (cnt_r == LIMIT);

  // wait-cycle counter, saturating at the limit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_r <= 8'd0;
    end else if (clear) begin
      cnt_r <= 8'd0;
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetches and data accesses onto a single RAM port,
// alternating on contention and aborting accesses on RAM error or timeout.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  memory_arbiter_if.master        bus
);

  arb_state_t  state_r, next_state_s;
  logic        last_d_r;
  logic        ihit_r, dhit_r, err_r;
  logic [31:0] iload_r, dload_r;
  logic        set_err_s, cap_i_s, cap_d_s, d_req_s, in_acc_s, expired_s;
  logic        ren_s, wen_s;
  logic [31:0] addr_s, store_s;

  assign in_acc_s = (state_r == IACC) || (state_r == DACC);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (!in_acc_s),
    .enable  (in_acc_s && (bus.ramstate != ACCESS)),
    .expired (expired_s)
  );

  // next-state decode and RAM strobe generation
  always_comb begin
    next_state_s = state_r;
    set_err_s    = 1'b0;
    cap_i_s      = 1'b0;
    cap_d_s      = 1'b0;
    ren_s        = 1'b0;
    wen_s        = 1'b0;
    addr_s       = 32'h0;
    store_s      = 32'h0;
    d_req_s      = data_req(bus.dRen, bus.dWen);
    case (state_r)
      IDLE: begin
        if (d_req_s && bus.iRen) begin
          next_state_s = last_d_r ? IACC : DACC;
        end else if (d_req_s) begin
          next_state_s = DACC;
        end else if (bus.iRen) begin
          next_state_s = IACC;
        end else begin
          next_state_s = IDLE;
        end
      end
      IACC: begin
        ren_s  = 1'b1;
        addr_s = bus.iaddr;
        if (!bus.iRen) begin
          next_state_s = IDLE;
        end else if (bus.ramstate == ERROR) begin
          set_err_s    = 1'b1;
          next_state_s = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          cap_i_s      = 1'b1;
          next_state_s = IRESP;
        end else if (expired_s) begin
          set_err_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = IACC;
        end
      end
      DACC: begin
        // a simultaneous read and write request is treated as a write
        wen_s   = bus.dWen;
        ren_s   = bus.dRen & ~bus.dWen;
        addr_s  = bus.daddr;
        store_s = bus.dstore;
        if (!d_req_s) begin
          next_state_s = IDLE;
        end else if (bus.ramstate == ERROR) begin
          set_err_s    = 1'b1;
          next_state_s = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          cap_d_s      = ren_s;
          next_state_s = DRESP;
        end else if (expired_s) begin
          set_err_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = DACC;
        end
      end
      IRESP:   next_state_s = IDLE;
      DRESP:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // registered hits, load data, sticky error and last-served side
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ihit_r   <= 1'b0;
      dhit_r   <= 1'b0;
      iload_r  <= 32'h0;
      dload_r  <= 32'h0;
      err_r    <= 1'b0;
      last_d_r <= 1'b0;
    end else begin
      ihit_r <= (next_state_s == IRESP);
      dhit_r <= (next_state_s == DRESP);
      err_r  <= err_r | set_err_s;
      if (cap_i_s) iload_r <= bus.ramload;
      if (cap_d_s) dload_r <= bus.ramload;
      if (state_r == IRESP) begin
        last_d_r <= 1'b0;
      end else if (state_r == DRESP) begin
        last_d_r <= 1'b1;
      end
    end
  end

  assign bus.iHit     = ihit_r;
  assign bus.dHit     = dhit_r;
  assign bus.iload    = iload_r;
  assign bus.dload    = dload_r;
  assign bus.mem_err  = err_r;
  assign bus.ramREN   = ren_s;
  assign bus.ramWEN   = wen_s;
  assign bus.ramaddr  = addr_s;
  assign bus.ramstore = store_s;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed bench for memory_arbiter against a transaction-level
// reference model of the arbitration, timeout and response rules.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 4;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // model: who owns the RAM (0 none, 1 fetch, 2 data), wait cycles, responses
  int          owner;
  int          waited;
  bit          resp_i, resp_d, last_d, m_err;
  logic [31:0] m_iload, m_dload;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0; waited = 0; resp_i = 1'b0; resp_d = 1'b0;
    last_d = 1'b0; m_err = 1'b0; m_iload = 32'h0; m_dload = 32'h0;
  endtask

  task automatic compare_all();
    logic er, ew;
    logic [31:0] ea, es;
    er = 1'b0; ew = 1'b0; ea = 32'h0; es = 32'h0;
    if (owner == 1) begin
      er = 1'b1; ea = bus.iaddr;
    end else if (owner == 2) begin
      ew = bus.dWen; er = bus.dRen & ~bus.dWen; ea = bus.daddr; es = bus.dstore;
    end
    check_val("iHit", bus.iHit, resp_i);
    check_val("dHit", bus.dHit, resp_d);
    check_val("both_hits", bus.iHit & bus.dHit, 1'b0);
    check_val("iload", bus.iload, m_iload);
    check_val("dload", bus.dload, m_dload);
    check_val("mem_err", bus.mem_err, m_err);
    check_val("ramREN", bus.ramREN, er);
    check_val("ramWEN", bus.ramWEN, ew);
    check_val("ramaddr", bus.ramaddr, ea);
    check_val("ramstore", bus.ramstore, es);
  endtask

  // advance the model over one clock edge using the inputs of this cycle
  task automatic model_next();
    bit dreq, rd;
    if (!nRST) return;
    dreq = bus.dRen | bus.dWen;
    rd   = bus.dRen & ~bus.dWen;
    if (resp_i || resp_d) begin
      last_d = resp_d; resp_i = 1'b0; resp_d = 1'b0;
    end else if (owner == 0) begin
      waited = 0;
      if (dreq && bus.iRen) owner = last_d ? 1 : 2;
      else if (dreq)        owner = 2;
      else if (bus.iRen)    owner = 1;
    end else begin
      if ((owner == 1 && !bus.iRen) || (owner == 2 && !dreq)) begin
        owner = 0;
      end else if (bus.ramstate == ERROR) begin
        m_err = 1'b1; owner = 0;
      end else if (bus.ramstate == ACCESS) begin
        if (owner == 1) begin m_iload = bus.ramload; resp_i = 1'b1; end
        else begin
          if (rd) m_dload = bus.ramload;
          resp_d = 1'b1;
        end
        owner = 0;
      end else if (waited + 1 == TO) begin
        m_err = 1'b1; owner = 0;
      end else begin
        waited++;
      end
    end
  endtask

  task automatic step();
    @(negedge CLK);
    compare_all();
    model_next();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iRen = 1'b0; bus.iaddr = 32'h0; bus.dRen = 1'b0; bus.dWen = 1'b0;
    bus.daddr = 32'h0; bus.dstore = 32'h0; bus.ramload = 32'h0; bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_random();
    int r;
    if (!bus.iRen && $urandom_range(0, 2) == 0) begin
      bus.iRen = 1'b1; bus.iaddr = $urandom;
    end
    if (!(bus.dRen || bus.dWen) && $urandom_range(0, 2) == 0) begin
      r = $urandom_range(0, 2);
      bus.dRen = (r != 1); bus.dWen = (r != 0);
      bus.daddr = $urandom; bus.dstore = $urandom;
    end
    r = $urandom_range(0, 99);
    bus.ramstate = (r < 1) ? ERROR : (r < 10) ? FREE : (r < 50) ? BUSY : ACCESS;
    bus.ramload = $urandom;
  endtask

  initial begin
    logic [31:0] saved_dload;
    bit hi, hd;
    clear_inputs();
    model_reset();
    #12;
    compare_all();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // zero-wait fetch
    bus.iRen = 1'b1; bus.iaddr = 32'h0000_0040;
    bus.ramstate = ACCESS; bus.ramload = 32'h2008_0001;
    step(); step();
    check_val("fetch_hit", bus.iHit, 1'b1);
    check_val("fetch_word", bus.iload, 32'h2008_0001);
    bus.iRen = 1'b0;
    step(); step();

    // contention: data first after reset-time tie break, then fetch
    do_reset();
    bus.iRen = 1'b1; bus.dRen = 1'b1; bus.daddr = 32'h0000_0200;
    bus.ramstate = ACCESS; bus.ramload = 32'h1234_5678;
    step(); step();
    check_val("tie_dhit", bus.dHit, 1'b1);
    bus.dRen = 1'b0; bus.ramload = 32'h0BAD_F00D;
    step(); step(); step();
    check_val("tie_ihit", bus.iHit, 1'b1);
    bus.iRen = 1'b0;
    step();

    // write with three busy cycles
    saved_dload = m_dload;
    bus.dWen = 1'b1; bus.daddr = 32'h0000_0100; bus.dstore = 32'hDEAD_BEEF;
    bus.ramstate = BUSY;
    step();
    for (int i = 0; i < 3; i++) step();
    bus.ramstate = ACCESS;
    step();
    check_val("write_hit", bus.dHit, 1'b1);
    check_val("write_dload", bus.dload, saved_dload);
    bus.dWen = 1'b0;
    step();

    // withdrawn fetch
    bus.iRen = 1'b1; bus.ramstate = BUSY;
    step(); step();
    bus.iRen = 1'b0;
    step(); step();

    // stuck RAM: timeout, sticky error, re-grant
    bus.iRen = 1'b1; bus.ramstate = BUSY;
    for (int i = 0; i < 9; i++) step();
    check_val("timeout_err", bus.mem_err, 1'b1);
    bus.iRen = 1'b0;
    step(); step();
    check_val("err_sticky", bus.mem_err, 1'b1);

    // async reset in the middle of a fetch
    bus.iRen = 1'b1; bus.ramstate = BUSY;
    step();
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    check_val("rst_ren", bus.ramREN, 1'b0);
    check_val("rst_err", bus.mem_err, 1'b0);
    step();
    nRST = 1'b1;
    bus.iRen = 1'b0;
    step(); step();

    // RAM error during a data read
    bus.dRen = 1'b1; bus.ramstate = ERROR;
    step(); step();
    check_val("derr_err", bus.mem_err, 1'b1);
    bus.dRen = 1'b0;
    step();

    // randomised traffic
    clear_inputs();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      hi = resp_i;
      hd = resp_d;
      step();
      if (hi) bus.iRen = 1'b0;
      if (hd) begin bus.dRen = 1'b0; bus.dWen = 1'b0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
